// File: rtl/dsp_seq_pkg.sv
// rtl/dsp_seq_pkg.sv - shared widths, defaults and FSM encoding for the DSP command sequencer
package dsp_seq_pkg;

  localparam int OPND_W          = 18;
  localparam int C_W             = 48;
  localparam int OPMODE_W        = 8;
  localparam int LATENCY_DEFAULT = 4;
  localparam int DEPTH_DEFAULT   = 4;

  localparam logic [OPMODE_W-1:0] OPMODE_BUBBLE = 8'h00;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic           carryout;
    logic [C_W-1:0] p;
  } dsp_res_t;

endpackage

// File: rtl/dsp_seq_if.sv
// rtl/dsp_seq_if.sv - command, DSP-slice and result signals of the sequencer
// master is the environment side, slave is the sequencer side.
interface dsp_seq_if;
  import dsp_seq_pkg::*;

  logic                CMD_VALID;
  logic                CMD_READY;
  logic [OPND_W-1:0]   CMD_A;
  logic [OPND_W-1:0]   CMD_B;
  logic [OPND_W-1:0]   CMD_D;
  logic [C_W-1:0]      CMD_C;
  logic [OPMODE_W-1:0] CMD_OPMODE;
  logic                CMD_CARRYIN;
  logic                FLUSH_REQ;

  logic [OPND_W-1:0]   DSP_A;
  logic [OPND_W-1:0]   DSP_B;
  logic [OPND_W-1:0]   DSP_D;
  logic [C_W-1:0]      DSP_C;
  logic [OPMODE_W-1:0] DSP_OPMODE;
  logic                DSP_CARRYIN;
  logic                DSP_CE;
  logic                DSP_RST;
  logic [C_W-1:0]      DSP_P;
  logic                DSP_CARRYOUT;

  logic                RES_VALID;
  logic                RES_READY;
  logic [C_W-1:0]      RES_P;
  logic                RES_CARRYOUT;

  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_D, CMD_C, CMD_OPMODE, CMD_CARRYIN, FLUSH_REQ,
    output DSP_P, DSP_CARRYOUT, RES_READY,
    input  CMD_READY, DSP_A, DSP_B, DSP_D, DSP_C, DSP_OPMODE, DSP_CARRYIN, DSP_CE, DSP_RST,
    input  RES_VALID, RES_P, RES_CARRYOUT
  );

  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_D, CMD_C, CMD_OPMODE, CMD_CARRYIN, FLUSH_REQ,
    input  DSP_P, DSP_CARRYOUT, RES_READY,
    output CMD_READY, DSP_A, DSP_B, DSP_D, DSP_C, DSP_OPMODE, DSP_CARRYIN, DSP_CE, DSP_RST,
    output RES_VALID, RES_P, RES_CARRYOUT
  );

endinterface

// File: rtl/dsp_seq_res_fifo.sv
// rtl/dsp_seq_res_fifo.sv - result FIFO; a pop frees the slot so push+pop at full is accepted
module dsp_seq_res_fifo
  import dsp_seq_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dsp_res_t      push_data,
  input  logic          pop,
  output dsp_res_t      head,
  output logic          empty,
  output logic [CW-1:0] count
);

  dsp_res_t      mem_q [DEPTH];
  dsp_res_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head  = mem_q[rd_ptr_q];
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dsp_cmd_sequencer.sv
// rtl/dsp_cmd_sequencer.sv - issues commands into a pipelined DSP slice and buffers tagged results
// Optional DSP_SEQ_PERF_EN enables the issue/stall counters; otherwise they read 0.
module dsp_cmd_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  dsp_seq_if.slave    bus,
  output logic [31:0] PERF_ISSUED,
  output logic [31:0] PERF_STALL
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int FW = $clog2(LATENCY + 1);

  seq_state_e          state_q, state_d;
  logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic [LATENCY-1:0]  tag_q, tag_d;
  logic                dsp_vld_q, dsp_vld_d;
  logic [OPND_W-1:0]   dsp_a_q, dsp_a_d;
  logic [OPND_W-1:0]   dsp_b_q, dsp_b_d;
  logic [OPND_W-1:0]   dsp_d_q, dsp_d_d;
  logic [C_W-1:0]      dsp_c_q, dsp_c_d;
  logic [OPMODE_W-1:0] dsp_opmode_q, dsp_opmode_d;
  logic                dsp_carryin_q, dsp_carryin_d;

  logic                cmd_ready;
  logic                credit_ok;
  logic                fire;
  logic                res_push;
  dsp_res_t            res_in;
  dsp_res_t            res_head;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  // Credits cover both results still in the DSP pipe and those already buffered.
  assign credit_ok = (SW'(inflight_q) + SW'(fifo_count)) < SW'(DEPTH);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    cmd_ready   = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FW'(LATENCY)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      ST_RUN: begin
        cmd_ready = credit_ok;
        if (bus.FLUSH_REQ) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    fire          = bus.CMD_VALID && cmd_ready;
    dsp_vld_d     = fire;
    dsp_a_d       = fire ? bus.CMD_A       : '0;
    dsp_b_d       = fire ? bus.CMD_B       : '0;
    dsp_d_d       = fire ? bus.CMD_D       : '0;
    dsp_c_d       = fire ? bus.CMD_C       : '0;
    dsp_opmode_d  = fire ? bus.CMD_OPMODE  : OPMODE_BUBBLE;
    dsp_carryin_d = fire ? bus.CMD_CARRYIN : 1'b0;

    // The tag follows the operand out of the DSP_* register, so it exits exactly when P is valid.
    tag_d    = tag_q << 1;
    tag_d[0] = dsp_vld_q;
    res_push = tag_q[LATENCY-1];

    res_in.p        = bus.DSP_P;
    res_in.carryout = bus.DSP_CARRYOUT;

    case ({fire, res_push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_FLUSH;
      flush_cnt_q   <= '0;
      inflight_q    <= '0;
      tag_q         <= '0;
      dsp_vld_q     <= 1'b0;
      dsp_a_q       <= '0;
      dsp_b_q       <= '0;
      dsp_d_q       <= '0;
      dsp_c_q       <= '0;
      dsp_opmode_q  <= OPMODE_BUBBLE;
      dsp_carryin_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      inflight_q    <= inflight_d;
      tag_q         <= tag_d;
      dsp_vld_q     <= dsp_vld_d;
      dsp_a_q       <= dsp_a_d;
      dsp_b_q       <= dsp_b_d;
      dsp_d_q       <= dsp_d_d;
      dsp_c_q       <= dsp_c_d;
      dsp_opmode_q  <= dsp_opmode_d;
      dsp_carryin_q <= dsp_carryin_d;
    end
  end

  dsp_seq_res_fifo #(
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (res_push),
    .push_data (res_in),
    .pop       (bus.RES_READY),
    .head      (res_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.CMD_READY    = cmd_ready;
  assign bus.DSP_A        = dsp_a_q;
  assign bus.DSP_B        = dsp_b_q;
  assign bus.DSP_D        = dsp_d_q;
  assign bus.DSP_C        = dsp_c_q;
  assign bus.DSP_OPMODE   = dsp_opmode_q;
  assign bus.DSP_CARRYIN  = dsp_carryin_q;
  assign bus.DSP_CE       = (state_q != ST_FLUSH);
  assign bus.DSP_RST      = (state_q == ST_FLUSH);
  assign bus.RES_VALID    = !fifo_empty;
  assign bus.RES_P        = res_head.p;
  assign bus.RES_CARRYOUT = res_head.carryout;

`ifdef DSP_SEQ_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q + {31'b0, fire};
    perf_stall_d  = perf_stall_q +
                    {31'b0, (state_q == ST_RUN) && bus.CMD_VALID && !cmd_ready};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign PERF_ISSUED = perf_issued_q;
  assign PERF_STALL  = perf_stall_q;
`else
  assign PERF_ISSUED = '0;
  assign PERF_STALL  = '0;
`endif

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// tb/tb_dsp_cmd_sequencer.sv - scoreboard bench for dsp_cmd_sequencer with a behavioural DSP slice
`timescale 1ns/1ps
module tb_dsp_cmd_sequencer;
  import dsp_seq_pkg::*;

  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] perf_issued, perf_stall;

  dsp_seq_if bus_if ();

  dsp_cmd_sequencer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus_if),
    .PERF_ISSUED (perf_issued),
    .PERF_STALL  (perf_stall)
  );

  logic     f_push, f_pop, f_empty;
  dsp_res_t f_din, f_head;
  logic [2:0] f_count;

  dsp_seq_res_fifo #(.DEPTH(DEP)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (f_push),
    .push_data (f_din),
    .pop       (f_pop),
    .head      (f_head),
    .empty     (f_empty),
    .count     (f_count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int n_pop  = 0;
  int n_stall = 0;
  logic [48:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // DSP48A1-style arithmetic: pre-adder, multiplier, X/Z muxes, post-adder/subtracter.
  function automatic logic [48:0] dsp_f(input logic [17:0] a, input logic [17:0] b,
                                        input logic [17:0] d, input logic [47:0] c,
                                        input logic [7:0] op, input logic cin,
                                        input logic [47:0] p);
    logic [17:0] pre;
    logic [47:0] x, z;
    pre = op[4] ? (op[6] ? d - b : d + b) : b;
    case (op[1:0])
      2'd0:    x = '0;
      2'd1:    x = 48'(a) * 48'(pre);
      2'd2:    x = p;
      default: x = {d[11:0], a, b};
    endcase
    case (op[3:2])
      2'd2:    z = p;
      2'd3:    z = c;
      default: z = '0;
    endcase
    return op[7] ? ({1'b0, z} - ({1'b0, x} + 49'(cin))) : ({1'b0, z} + {1'b0, x} + 49'(cin));
  endfunction

  logic [48:0] dsp_pipe [LAT];
  always @(posedge CLK) begin
    if (bus_if.DSP_RST) begin
      for (int i = 0; i < LAT; i++) dsp_pipe[i] <= '0;
    end else if (bus_if.DSP_CE) begin
      dsp_pipe[0] <= dsp_f(bus_if.DSP_A, bus_if.DSP_B, bus_if.DSP_D, bus_if.DSP_C,
                           bus_if.DSP_OPMODE, bus_if.DSP_CARRYIN, bus_if.DSP_P);
      for (int i = 1; i < LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
  end
  assign bus_if.DSP_P        = dsp_pipe[LAT-1][47:0];
  assign bus_if.DSP_CARRYOUT = dsp_pipe[LAT-1][48];

  always @(negedge CLK) begin
    logic [48:0] e;
    if (!RST) begin
      if (bus_if.CMD_VALID && bus_if.CMD_READY) begin
        sb_q.push_back(dsp_f(bus_if.CMD_A, bus_if.CMD_B, bus_if.CMD_D, bus_if.CMD_C,
                             bus_if.CMD_OPMODE, bus_if.CMD_CARRYIN, 48'h0));
        n_acc++;
      end
      if (bus_if.CMD_VALID && !bus_if.CMD_READY) n_stall++;
      if (bus_if.RES_VALID && bus_if.RES_READY) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("res_p", 64'(bus_if.RES_P), 64'(e[47:0]));
          chk("res_carryout", 64'(bus_if.RES_CARRYOUT), 64'(e[48]));
        end
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_cmd(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                           input logic [47:0] c, input logic [7:0] op, input logic cin);
    bus_if.CMD_A       = a;
    bus_if.CMD_B       = b;
    bus_if.CMD_D       = d;
    bus_if.CMD_C       = c;
    bus_if.CMD_OPMODE  = op;
    bus_if.CMD_CARRYIN = cin;
    bus_if.CMD_VALID   = 1'b1;
  endtask

  task automatic drive_k(input int k);
    drive_cmd(18'(k * 7 + 3), 18'(k + 1), 18'(k * 3 + 40), 48'(k * 1000 + 5),
              k[0] ? 8'h1D : 8'hDD, k[0]);
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                      input logic [47:0] c, input logic [7:0] op, input logic cin);
    int n;
    n = 0;
    drive_cmd(a, b, d, c, op, cin);
    while (!bus_if.CMD_READY && n < 20) begin
      tick();
      n++;
    end
    chk("send_accept", 64'(n < 20), 64'd1);
    tick();
    bus_if.CMD_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_perf(input string tag);
`ifdef DSP_SEQ_PERF_EN
    chk({tag, "_issued"}, 64'(perf_issued), 64'(n_acc));
    chk({tag, "_stall"}, 64'(perf_stall), 64'(n_stall));
`else
    chk({tag, "_issued"}, 64'(perf_issued), 64'd0);
    chk({tag, "_stall"}, 64'(perf_stall), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   n, m, k, pops0;
  logic vl;

  initial begin
    bus_if.CMD_VALID = 1'b0;
    bus_if.FLUSH_REQ = 1'b0;
    bus_if.RES_READY = 1'b0;
    drive_cmd('0, '0, '0, '0, '0, 1'b0);
    bus_if.CMD_VALID = 1'b0;
    f_push = 1'b0;
    f_pop  = 1'b0;
    f_din  = '0;

    RST = 1'b1;
    repeat (3) tick();
    chk("rst_res_valid", 64'(bus_if.RES_VALID), 64'd0);
    chk("rst_cmd_ready", 64'(bus_if.CMD_READY), 64'd0);
    chk("rst_dsp_ce", 64'(bus_if.DSP_CE), 64'd0);
    chk("rst_dsp_rst", 64'(bus_if.DSP_RST), 64'd1);
    chk("rst_dsp_a", 64'(bus_if.DSP_A), 64'd0);
    check_perf("rst_perf");

    RST = 1'b0;
    n = 0;
    while (bus_if.DSP_RST && n < 20) begin
      tick();
      n++;
    end
    chk("flush_cycles", 64'(n), 64'd5);
    chk("run_cmd_ready", 64'(bus_if.CMD_READY), 64'd1);
    chk("run_res_valid", 64'(bus_if.RES_VALID), 64'd0);
    chk("run_dsp_ce", 64'(bus_if.DSP_CE), 64'd1);

    // single operation: P = C - A*(D-B) = 350 - 20*15 = 50
    bus_if.RES_READY = 1'b1;
    send(18'd20, 18'd10, 18'd25, 48'd350, 8'b11011101, 1'b0);
    n = 0;
    while (!bus_if.RES_VALID && n < 20) begin
      tick();
      n++;
    end
    chk("res_latency", 64'(n), 64'd5);
    chk("res_p_0x32", 64'(bus_if.RES_P), 64'h32);
    chk("res_co_0", 64'(bus_if.RES_CARRYOUT), 64'd0);
    tick();
    chk("bubble_opmode", 64'(bus_if.DSP_OPMODE), 64'd0);
    chk("bubble_a", 64'(bus_if.DSP_A), 64'd0);
    chk("bubble_c", 64'(bus_if.DSP_C), 64'd0);
    wait_drain();

    // carry-out and concatenated-X patterns
    send(18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 8'h0D, 1'b0);
    send(18'h2_0001, 18'h0_1234, 18'h0_0ABC, 48'd0, 8'h03, 1'b1);
    wait_drain();

    // back-pressure: 6 commands, only DEPTH accepted while results are held
    bus_if.RES_READY = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 6) drive_k(k);
      if (bus_if.CMD_READY && k < 6) k++;
      tick();
    end
    chk("bp_accepted", 64'(k), 64'd4);
    chk("bp_cmd_ready", 64'(bus_if.CMD_READY), 64'd0);
    check_perf("bp_perf");
    bus_if.RES_READY = 1'b1;
    n = 0;
    while (k < 6 && n < 40) begin
      drive_k(k);
      if (bus_if.CMD_READY) k++;
      tick();
      n++;
    end
    bus_if.CMD_VALID = 1'b0;
    chk("bp_all_accepted", 64'(k), 64'd6);
    wait_drain();

    // flush with two operations in flight
    bus_if.RES_READY = 1'b0;
    pops0 = n_pop;
    send(18'd5, 18'd3, 18'd9, 48'd1000, 8'hDD, 1'b0);
    send(18'd7, 18'd2, 18'd4, 48'd77, 8'h1D, 1'b1);
    bus_if.FLUSH_REQ = 1'b1;
    tick();
    bus_if.FLUSH_REQ = 1'b0;
    chk("drain_cmd_ready", 64'(bus_if.CMD_READY), 64'd0);
    chk("drain_dsp_ce", 64'(bus_if.DSP_CE), 64'd1);
    chk("drain_dsp_rst", 64'(bus_if.DSP_RST), 64'd0);
    n = 0;
    while (!bus_if.DSP_RST && n < 20) begin
      tick();
      n++;
    end
    chk("drain_to_flush", 64'(n < 20), 64'd1);
    m  = 0;
    vl = 1'b1;
    while (bus_if.DSP_RST && m < 20) begin
      vl &= bus_if.RES_VALID;
      bus_if.FLUSH_REQ = (m == 1);
      tick();
      m++;
    end
    bus_if.FLUSH_REQ = 1'b0;
    chk("flush_pulse", 64'(m), 64'd5);
    chk("flush_res_valid", 64'(vl), 64'd1);
    chk("flush_cmd_ready", 64'(bus_if.CMD_READY), 64'd1);
    bus_if.RES_READY = 1'b1;
    wait_drain();
    chk("flush_results", 64'(n_pop - pops0), 64'd2);

    // reset with three buffered results
    bus_if.RES_READY = 1'b0;
    send(18'd11, 18'd1, 18'd2, 48'd3, 8'hDD, 1'b0);
    send(18'd12, 18'd1, 18'd2, 48'd3, 8'hDD, 1'b0);
    send(18'd13, 18'd1, 18'd2, 48'd3, 8'hDD, 1'b0);
    repeat (8) tick();
    chk("buf3_res_valid", 64'(bus_if.RES_VALID), 64'd1);
    check_perf("pre_rst_perf");
    RST = 1'b1;
    sb_q.delete();
    n_acc   = 0;
    n_stall = 0;
    tick();
    chk("rst_mid_res_valid", 64'(bus_if.RES_VALID), 64'd0);
    chk("rst_mid_dsp_rst", 64'(bus_if.DSP_RST), 64'd1);
    chk("rst_mid_cmd_ready", 64'(bus_if.CMD_READY), 64'd0);
    RST = 1'b0;
    bus_if.RES_READY = 1'b1;
    n = 0;
    while (!bus_if.CMD_READY && n < 20) begin
      tick();
      n++;
    end
    chk("rst_mid_discard", 64'(bus_if.RES_VALID), 64'd0);
    send(18'd3, 18'd4, 18'd0, 48'hFFFF_FFFF_FFF0, 8'h0D, 1'b1);
    wait_drain();
    check_perf("end_perf");

    // FIFO: simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      f_push = 1'b1;
      f_din.p = 48'(16'hA0 + i);
      f_din.carryout = i[0];
      tick();
    end
    f_push = 1'b0;
    chk("fifo_full_count", 64'(f_count), 64'd4);
    for (int i = 0; i < 2; i++) begin
      f_push = 1'b1;
      f_pop  = 1'b1;
      f_din.p = 48'(16'hA4 + i);
      f_din.carryout = i[0];
      chk("fifo_pp_head", 64'(f_head.p), 64'(16'hA0 + i));
      tick();
      chk("fifo_pp_count", 64'(f_count), 64'd4);
    end
    f_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f_pop = 1'b1;
      chk("fifo_order", 64'(f_head.p), 64'(16'hA2 + i));
      tick();
    end
    f_pop = 1'b0;
    chk("fifo_empty", 64'(f_empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_cmd_sequencer.md
DSP_CMD_SEQUENCER -- requirements
Module: dsp_cmd_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the cycle count from an operand appearing on the DSP_* outputs to its P/CARRYOUT result being valid on DSP_P/DSP_CARRYOUT.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the result FIFO depth and the maximum number of in-flight plus buffered operations.
REQ-003 SHALL use one clock, CLK; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 CMD_VALID in 1 / CMD_READY out 1  command handshake.
REQ-007 CMD_A, CMD_B, CMD_D  in  18 each  operands; CMD_C  in  48; CMD_OPMODE  in  8; CMD_CARRYIN  in  1.
REQ-008 FLUSH_REQ  in  1  request for a pipeline drain plus DSP reset.
REQ-009 DSP_A, DSP_B, DSP_D  out  18; DSP_C  out  48; DSP_OPMODE  out  8; DSP_CARRYIN  out  1  registered operands to the DSP.
REQ-010 DSP_CE  out  1  drives every CE* of the DSP; DSP_RST  out  1  drives every RST* of the DSP.
REQ-011 DSP_P  in  48; DSP_CARRYOUT  in  1  results returned from the DSP.
REQ-012 RES_VALID out 1 / RES_READY in 1  result handshake; RES_P  out  48; RES_CARRYOUT  out  1.
REQ-013 PERF_ISSUED, PERF_STALL  out  32 each  performance counters.

Function
REQ-014 The FSM SHALL have three states: FLUSH, RUN and DRAIN.
REQ-015 FLUSH SHALL hold DSP_RST=1 and CMD_READY=0 for LATENCY+1 cycles, then move to RUN.
REQ-016 In RUN, CMD_READY SHALL be 1 only when (in-flight count + FIFO occupancy) < DEPTH; this credit rule guarantees the FIFO never overflows.
REQ-017 When CMD_VALID&&CMD_READY, the CMD_* fields SHALL appear on DSP_* on the next cycle, and a valid tag SHALL enter a LATENCY-deep shift register.
REQ-018 On a cycle with no issue, DSP_OPMODE SHALL be 8'h00 and all operands and DSP_CARRYIN SHALL be 0 (bubble), with no valid tag; bubble results SHALL be discarded.
REQ-019 Accumulation chains (Z=P feedback) are valid only when their commands are issued back-to-back.
REQ-020 When the tag exits the shift register, DSP_P and DSP_CARRYOUT SHALL be written into the FIFO in the same cycle.
REQ-021 DSP_CE SHALL be 1 in RUN and DRAIN and 0 in FLUSH.
REQ-022 RES_VALID SHALL be high while the FIFO is non-empty; an entry SHALL be popped on RES_VALID&&RES_READY; RES_P and RES_CARRYOUT SHALL show the FIFO head.
REQ-023 Push and pop SHALL be allowed in the same cycle, including at full; occupancy is unchanged.
REQ-024 FLUSH_REQ in RUN SHALL move the FSM to DRAIN, where CMD_READY=0.
REQ-025 DRAIN SHALL move to FLUSH once the in-flight count is 0; FIFO contents SHALL be kept and remain poppable.
REQ-026 FLUSH_REQ in FLUSH or DRAIN SHALL be ignored.

Reset
REQ-027 RST SHALL:
- put the FSM in FLUSH;
- clear the FIFO, the tags, the counters and all DSP_* operands;
- drive RES_VALID=0, CMD_READY=0, DSP_CE=0 and DSP_RST=1.
REQ-028 RST mid-operation SHALL discard all in-flight and buffered results.

Configuration
REQ-029 With macro DSP_SEQ_PERF_EN defined, PERF_ISSUED SHALL count accepted commands and PERF_STALL SHALL count cycles in RUN with CMD_VALID=1 and CMD_READY=0; both SHALL wrap at 2^32.
REQ-030 Without DSP_SEQ_PERF_EN, both ports SHALL exist and be tied to 0.

Structure
REQ-031 Package dsp_seq_pkg SHALL hold:
- the width constants (18, 48, 8);
- the LATENCY and DEPTH defaults;
- the FSM state enum;
- the bubble OPMODE constant.
REQ-032 The result FIFO SHALL be the sub-module dsp_seq_res_fifo.

Verification
REQ-033 Reset, then release: DSP_RST=1 for 5 cycles, then CMD_READY=1 and RES_VALID=0.
REQ-034 OPMODE 8'b11011101, A=20, B=10, C=350, D=25, RES_READY=1, DSP attached with LATENCY=4 -> RES_VALID 5 cycles after acceptance with RES_P=48'h32 and RES_CARRYOUT=0.
REQ-035 RES_READY=0 with 6 back-to-back commands -> CMD_READY drops after the 4th; no result is lost; PERF_STALL increments.
REQ-036 FLUSH_REQ with 2 operations in flight -> DRAIN; both results reach the FIFO; then DSP_RST is pulsed for 5 cycles; RES_VALID stays 1.
REQ-037 Full FIFO with simultaneous push and pop -> occupancy stays 4 and the order is preserved.
REQ-038 RST asserted with 3 results buffered -> RES_VALID=0 on the next cycle and the FSM is in FLUSH.
